// File: rtl/cnratr_pkg.sv
// Shared types and constants for the CNRATR trim calibration controller.
package cnratr_pkg;

  localparam int unsigned NVAR_DEFAULT = 20;
  localparam int unsigned CODE_W       = 5;
  localparam int unsigned CNT_W        = 8;
  localparam int unsigned BIT_W        = 3;
  localparam int unsigned TOP_BIT      = 4;

  // Variant index = col_idx * N_FIN + fin_idx
  // col {2,4,8,12}C, fingers {1F2,2F0,4F0,8F0,12F0}
  localparam int unsigned N_COL = 4;
  localparam int unsigned N_FIN = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRIAL = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic {
    PH_PCH = 1'b0,
    PH_NCH = 1'b1
  } phase_e;

  // Map a (column, finger) pair onto the flat variant index.
  function automatic logic [CODE_W-1:0] variant_idx(input logic [1:0] col_idx,
                                                    input logic [2:0] fin_idx);
    return CODE_W'(32'(col_idx) * N_FIN + 32'(fin_idx));
  endfunction

endpackage

// File: rtl/cnratr_trim_ctrl_if.sv
// Control / comparator / gate-select bundle between the trim controller and its environment.
interface cnratr_trim_ctrl_if
  import cnratr_pkg::*;
#(
  parameter int unsigned NVAR = NVAR_DEFAULT
) ();

  logic              start_i;
  logic              abort_i;
  logic              cmp_i;
  logic [NVAR-1:0]   pch_sel_o;
  logic [NVAR-1:0]   nch_sel_o;
  logic [CODE_W-1:0] pch_code_o;
  logic [CODE_W-1:0] nch_code_o;
  logic              busy_o;
  logic              done_o;

  modport slave (
    input  start_i, abort_i, cmp_i,
    output pch_sel_o, nch_sel_o, pch_code_o, nch_code_o, busy_o, done_o
  );

  modport master (
    output start_i, abort_i, cmp_i,
    input  pch_sel_o, nch_sel_o, pch_code_o, nch_code_o, busy_o, done_o
  );

endinterface

// File: rtl/cnratr_onehot_dec.sv
// Variant index to one-hot gate enable; out-of-range index or en_i=0 gives all zeros.
module cnratr_onehot_dec
  import cnratr_pkg::*;
#(
  parameter int unsigned NVAR = NVAR_DEFAULT
) (
  input  logic              en_i,
  input  logic [CODE_W-1:0] idx_i,
  output logic [NVAR-1:0]   onehot_o
);

  // Compare against every legal index so indices >= NVAR select nothing
  always_comb begin
    onehot_o = '0;
    for (int unsigned i = 0; i < NVAR; i++) begin
      if (en_i && (idx_i == CODE_W'(i))) onehot_o[i] = 1'b1;
    end
  end

endmodule

// File: rtl/cnratr_trim_ctrl.sv
// Successive-approximation trim of PCH then NCH variant arrays against a comparator.
module cnratr_trim_ctrl
  import cnratr_pkg::*;
#(
  parameter int unsigned SETTLE = 4,
  parameter int unsigned NVAR   = NVAR_DEFAULT
) (
  input logic               clk,
  input logic               rst,
  cnratr_trim_ctrl_if.slave bus
);

  state_e             state_q;
  phase_e             phase_q;
  logic [BIT_W-1:0]   bit_q;
  logic [CODE_W-1:0]  code_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CODE_W-1:0]  pch_code_q;
  logic [CODE_W-1:0]  nch_code_q;
  logic               pch_vld_q;
  logic               nch_vld_q;
  logic               busy_q;
  logic               done_q;

  logic [CODE_W-1:0]  trial_c;
  logic               trial_ok_c;
  logic               active_c;
  logic               finish_c;
  logic [CODE_W-1:0]  new_code_c;
  logic [CODE_W-1:0]  pch_idx_c;
  logic [CODE_W-1:0]  nch_idx_c;
  logic               pch_en_c;
  logic               nch_en_c;

  // Trial value, bit-completion condition and select indices derived from state
  always_comb begin
    trial_c    = code_q | (CODE_W'(1) << bit_q);
    trial_ok_c = 32'(trial_c) < NVAR;
    active_c   = (state_q == ST_TRIAL) || (state_q == ST_WAIT);
    finish_c   = ((state_q == ST_TRIAL) && !trial_ok_c) ||
                 ((state_q == ST_WAIT) && (cnt_q == CNT_W'(1)));
    new_code_c = code_q;
    if ((state_q == ST_WAIT) && bus.cmp_i) new_code_c = trial_c;

    pch_idx_c = pch_code_q;
    pch_en_c  = pch_vld_q;
    nch_idx_c = nch_code_q;
    nch_en_c  = nch_vld_q;
    if (active_c && (phase_q == PH_PCH)) begin
      pch_idx_c = trial_c;
      pch_en_c  = 1'b1;
    end
    if (active_c && (phase_q == PH_NCH)) begin
      nch_idx_c = trial_c;
      nch_en_c  = 1'b1;
    end
  end

  // Calibration FSM; bit completion overrides the per-state default moves
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      phase_q    <= PH_PCH;
      bit_q      <= '0;
      code_q     <= '0;
      cnt_q      <= '0;
      pch_code_q <= '0;
      nch_code_q <= '0;
      pch_vld_q  <= 1'b0;
      nch_vld_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start_i) begin
            state_q <= ST_TRIAL;
            phase_q <= PH_PCH;
            bit_q   <= BIT_W'(TOP_BIT);
            code_q  <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_TRIAL: begin
          if (bus.abort_i) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (trial_ok_c) begin
            state_q <= ST_WAIT;
            cnt_q   <= CNT_W'(SETTLE);
          end
        end
        ST_WAIT: begin
          if (bus.abort_i) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (cnt_q != CNT_W'(1)) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase

      if (finish_c && !bus.abort_i) begin
        if (bit_q != '0) begin
          state_q <= ST_TRIAL;
          bit_q   <= bit_q - BIT_W'(1);
          code_q  <= new_code_c;
        end else if (phase_q == PH_PCH) begin
          state_q    <= ST_TRIAL;
          pch_code_q <= new_code_c;
          pch_vld_q  <= 1'b1;
          phase_q    <= PH_NCH;
          code_q     <= '0;
          bit_q      <= BIT_W'(TOP_BIT);
        end else begin
          state_q    <= ST_DONE;
          nch_code_q <= new_code_c;
          nch_vld_q  <= 1'b1;
          busy_q     <= 1'b0;
          done_q     <= 1'b1;
        end
      end
    end
  end

  cnratr_onehot_dec #(.NVAR(NVAR)) u_pch_dec (
    .en_i     (pch_en_c),
    .idx_i    (pch_idx_c),
    .onehot_o (bus.pch_sel_o)
  );

  cnratr_onehot_dec #(.NVAR(NVAR)) u_nch_dec (
    .en_i     (nch_en_c),
    .idx_i    (nch_idx_c),
    .onehot_o (bus.nch_sel_o)
  );

  assign bus.pch_code_o = pch_code_q;
  assign bus.nch_code_o = nch_code_q;
  assign bus.busy_o     = busy_q;
  assign bus.done_o     = done_q;

endmodule

// File: tb/tb_cnratr_trim_ctrl.sv
// Bench for cnratr_trim_ctrl: threshold comparator environment plus reference model.
module tb_cnratr_trim_ctrl;
  import cnratr_pkg::*;

  localparam int unsigned SETTLE = 4;
  localparam int unsigned NVAR   = 20;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cnratr_trim_ctrl_if #(.NVAR(NVAR)) bus ();

  cnratr_trim_ctrl #(.SETTLE(SETTLE), .NVAR(NVAR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // A monotone comparator settles on the largest legal index not above target
  function automatic int exp_code(input int target);
    if (target < 0) return 0;
    if (target > int'(NVAR) - 1) return int'(NVAR) - 1;
    return target;
  endfunction

  // Cycles spent in one phase: each bit costs 1, plus SETTLE when the trial is legal
  function automatic int exp_lat(input int target);
    int code = 0;
    int lat  = 0;
    for (int b = 4; b >= 0; b--) begin
      int trial = code + (1 << b);
      if (trial >= int'(NVAR)) lat += 1;
      else begin
        lat += 1 + int'(SETTLE);
        if (trial <= target) code = trial;
      end
    end
    return lat;
  endfunction

  function automatic logic [31:0] onehot(input int idx);
    return 32'(1) << idx;
  endfunction

  // Comparator: strength below target when the selected variant index <= target
  function automatic logic cmp_of(input logic [NVAR-1:0] sel, input int target);
    for (int i = 0; i < int'(NVAR); i++) begin
      if (sel[i]) return (i <= target);
    end
    return 1'b0;
  endfunction

  // One calibration: start sampled at the edge before cycle 1, done expected in cycle lt
  task automatic run(input int tp, input int tn, input bit hold, input int abort_at,
                     output int done_cyc, output int n_done);
    int lp, lt, maxk;
    lp   = exp_lat(tp);
    lt   = lp + exp_lat(tn) + 1;
    maxk = (abort_at > 0) ? abort_at + 4 : lt + 2;
    done_cyc = -1;
    n_done   = 0;
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.cmp_i   = 1'b0;
    @(posedge clk);
    for (int k = 1; k <= maxk; k++) begin
      @(negedge clk);
      if (!hold) bus.start_i = 1'b0;
      bus.abort_i = (k == abort_at);
      bus.cmp_i   = (k <= lp) ? cmp_of(bus.pch_sel_o, tp) : cmp_of(bus.nch_sel_o, tn);
      if (k == 1) check("busy_after_start", 32'(bus.busy_o), 32'(1));
      if (abort_at == 0 && k == lt) check("busy_in_done", 32'(bus.busy_o), 32'(0));
      if (abort_at > 0 && k == abort_at + 1) check("abort_busy", 32'(bus.busy_o), 32'(0));
      if (hold && k == lt + 1) check("hold_idle_busy", 32'(bus.busy_o), 32'(0));
      if (hold && k == lt + 2) check("hold_restart_busy", 32'(bus.busy_o), 32'(1));
      if (bus.done_o) begin
        n_done++;
        if (done_cyc < 0) done_cyc = k;
      end
    end
    bus.start_i = 1'b0;
    bus.abort_i = 1'b0;
  endtask

  task automatic check_result(input string tag, input int tp, input int tn,
                              input int dc, input int nd);
    int lt = exp_lat(tp) + exp_lat(tn) + 1;
    check({tag, "_latency"}, 32'(dc), 32'(lt));
    check({tag, "_ndone"}, 32'(nd), 32'(1));
    check({tag, "_pcode"}, 32'(bus.pch_code_o), 32'(exp_code(tp)));
    check({tag, "_ncode"}, 32'(bus.nch_code_o), 32'(exp_code(tn)));
    check({tag, "_psel"}, 32'(bus.pch_sel_o), onehot(exp_code(tp)));
    check({tag, "_nsel"}, 32'(bus.nch_sel_o), onehot(exp_code(tn)));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(bus.busy_o), 32'(0));
    check({tag, "_done"}, 32'(bus.done_o), 32'(0));
    check({tag, "_pcode"}, 32'(bus.pch_code_o), 32'(0));
    check({tag, "_ncode"}, 32'(bus.nch_code_o), 32'(0));
    check({tag, "_psel"}, 32'(bus.pch_sel_o), 32'(0));
    check({tag, "_nsel"}, 32'(bus.nch_sel_o), 32'(0));
  endtask

  initial begin
    int dc, nd, tp, tn, lp;
    bit seen;
    rst         = 1'b1;
    bus.start_i = 1'b0;
    bus.abort_i = 1'b0;
    bus.cmp_i   = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Always keep: codes 19/19, done 35 cycles after start
    run(31, 31, 1'b0, 0, dc, nd);
    check_result("keep_all", 31, 31, dc, nd);
    check("keep_all_lat35", 32'(dc), 32'(35));

    // Never keep: codes 0/0, done 51 cycles after start
    run(-1, -1, 1'b0, 0, dc, nd);
    check_result("keep_none", -1, -1, dc, nd);
    check("keep_none_lat51", 32'(dc), 32'(51));

    // Distinct targets per phase
    run(13, 5, 1'b0, 0, dc, nd);
    check_result("tgt_13_5", 13, 5, dc, nd);

    // Abort during the first NCH WAIT after a 19/19 run
    run(31, 31, 1'b0, 0, dc, nd);
    check_result("pre_abort", 31, 31, dc, nd);
    tp = int'($urandom_range(0, 18));
    lp = exp_lat(tp);
    run(tp, 3, 1'b0, lp + 3, dc, nd);
    check("abort_ndone", 32'(nd), 32'(0));
    check("abort_busy_after", 32'(bus.busy_o), 32'(0));
    check("abort_pcode", 32'(bus.pch_code_o), 32'(exp_code(tp)));
    check("abort_ncode", 32'(bus.nch_code_o), 32'(19));
    check("abort_nsel", 32'(bus.nch_sel_o), onehot(19));

    // Async reset in PCH WAIT clears everything immediately
    @(negedge clk);
    bus.start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.cmp_i   = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check_all_zero("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    run(7, 17, 1'b0, 0, dc, nd);
    check_result("post_reset", 7, 17, dc, nd);

    // start held high: one done per run, restart only after DONE
    run(31, 31, 1'b1, 0, dc, nd);
    check("hold_latency", 32'(dc), 32'(exp_lat(31) * 2 + 1));
    check("hold_ndone", 32'(nd), 32'(1));
    bus.cmp_i = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      if (bus.done_o) seen = 1'b1;
    end
    check("hold_rerun_done", 32'(seen), 32'(1));

    // Randomized targets, including out-of-range ones
    repeat (8) begin
      tp = int'($urandom_range(0, 40)) - 5;
      tn = int'($urandom_range(0, 40)) - 5;
      run(tp, tn, 1'b0, 0, dc, nd);
      check_result("rand", tp, tn, dc, nd);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cnratr_trim_ctrl.md
CNRATR_TRIM_CTRL -- requirements
Module: cnratr_trim_ctrl

Interface
REQ-001 The module SHALL have parameter SETTLE, default 4, giving the comparator settle wait in clock cycles per evaluated trial (legal range 1..255).
REQ-002 The module SHALL have parameter NVAR, default 20, giving the device variants per array; variant index = col_idx*5 + fin_idx, col {2,4,8,12}C, fingers {1F2,2F0,4F0,8F0,12F0}.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset (one clock; reset asynchronous active-high, fixed).
REQ-005 The module SHALL have port start_i, input, 1 bit: request a full calibration (PCH phase, then NCH phase).
REQ-006 The module SHALL have port abort_i, input, 1 bit: cancel a calibration in progress.
REQ-007 The module SHALL have port cmp_i, input, 1 bit: comparator, 1 = strength below target (keep bit).
REQ-008 The module SHALL have port pch_sel_o, output, NVAR bits: one-hot gate enable of the PCH variant array.
REQ-009 The module SHALL have port nch_sel_o, output, NVAR bits: one-hot gate enable of the NCH variant array.
REQ-010 The module SHALL have ports pch_code_o and nch_code_o, output, 5 bits each: last completed result index.
REQ-011 The module SHALL have port busy_o, output, 1 bit: calibration in progress.
REQ-012 The module SHALL have port done_o, output, 1 bit: single-cycle pulse on completion.

Function
REQ-013 States SHALL be IDLE, TRIAL, WAIT, DONE; a phase register selects PCH or NCH.
REQ-014 IDLE: start_i=1 sampled -> TRIAL, phase=PCH, bit=4, work code=0, busy_o=1 from next cycle.
REQ-015 TRIAL, 1 cycle: trial = code | (1<<bit); if trial >= NVAR, bit stays 0 and advances without settle; otherwise -> WAIT, counter loaded SETTLE.
REQ-016 WAIT SHALL last exactly SETTLE cycles; cmp_i is sampled in the last one: 1 keeps the bit, 0 clears it.
REQ-017 Bit completion: bit>0 -> TRIAL with bit-1; bit 0 in PCH -> store pch_code_o, phase=NCH, code=0, bit=4, TRIAL; bit 0 in NCH -> store nch_code_o, DONE.
REQ-018 DONE SHALL last 1 cycle with done_o=1, busy_o=0, then IDLE.
REQ-019 During the active phase its sel output SHALL be one-hot(trial) in TRIAL/WAIT; otherwise each sel SHALL be one-hot(stored code) if that code is valid, else all zeros.
REQ-020 start_i SHALL be ignored while busy_o=1 or in DONE.
REQ-021 abort_i in TRIAL/WAIT SHALL go to IDLE next cycle, busy_o=0, no done_o, stored codes and valid flags unchanged; abort_i has priority over a simultaneous cmp sample.
REQ-022 Work code SHALL never exceed NVAR-1; stored codes are always < NVAR.
REQ-023 Latency SHALL be per phase sum over bits 4..0 of (1+SETTLE) if evaluated, 1 if skipped.

Reset
REQ-024 On rst=1 the module SHALL immediately force IDLE, busy_o=0, done_o=0, pch_code_o=0, nch_code_o=0, valid flags=0, pch_sel_o=0, nch_sel_o=0.
REQ-025 Reset mid-calibration SHALL discard all progress; first start after rst release SHALL be accepted normally.

Structure
REQ-026 A package cnratr_pkg SHALL hold the state enum, phase enum, NVAR_DEFAULT=20, CODE_W=5, and variant-index mapping constants.
REQ-027 One sub-module cnratr_onehot_dec (5-bit index -> NVAR one-hot, zero for index >= NVAR) SHALL be instantiated twice.

Verification
REQ-028 cmp_i=1 constant, SETTLE=4: trials 16,24skip,20skip,18,19 -> pch_code_o=nch_code_o=19, done_o 35 cycles after start sampled.
REQ-029 cmp_i=0 constant: trials 16,8,4,2,1 each evaluated -> both codes 0, done_o 51 cycles after start sampled.
REQ-030 Target 13 PCH (cmp=1 iff trial<=13), target 5 NCH -> pch_code_o=13, nch_code_o=5, sel outputs bits 13 and 5 respectively after done.
REQ-031 abort_i in NCH WAIT after prior run codes 19/19 -> IDLE next cycle, no done_o, pch_code_o=new PCH result, nch_code_o=19.
REQ-032 rst asserted mid-PCH WAIT -> all outputs 0 same cycle; start re-accepted and completes normally.
REQ-033 start_i held high through busy -> exactly one done_o per run, no restart until after DONE.
